// File: rtl/oai33_arc_seq_pkg.sv
// Shared types, constants and the arc-to-drive-vector mapping for the oai33 arc sequencer.
package oai33_arc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int PIN_A1 = 0;
  localparam int PIN_A2 = 1;
  localparam int PIN_A3 = 2;
  localparam int PIN_B1 = 3;
  localparam int PIN_B2 = 4;
  localparam int PIN_B3 = 5;

  localparam int NUM_COND   = 7;
  localparam int NUM_ARCS   = 42;
  localparam int NUM_CHECKS = 84;

  // Vector layout is {A1,A2,A3,B1,B2,B3}; the toggled pin is 1 on rise (phase 0),
  // its group siblings stay 0, and the side condition drives the opposite group.
  function automatic logic [5:0] arc_vector(input logic [2:0] pin,
                                            input logic [2:0] cond,
                                            input logic       phase);
    logic [2:0] own;
    unique case (pin)
      3'(PIN_A1), 3'(PIN_B1): own = 3'b100;
      3'(PIN_A2), 3'(PIN_B2): own = 3'b010;
      default:                own = 3'b001;
    endcase
    if (phase) own = 3'b000;
    return (pin < 3'(PIN_B1)) ? {own, cond} : {cond, own};
  endfunction

endpackage

// File: rtl/oai33_golden_model.sv
// Combinational reference for the oai33 function: zn = !((a1|a2|a3) & (b1|b2|b3)).
module oai33_golden_model (
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic zn
);

  assign zn = ~((a1 | a2 | a3) & (b1 | b2 | b3));

endmodule

// File: rtl/oai33_arc_sequencer.sv
// Self-test sequencer sweeping all 84 conditional timing checks of one oai33 cell.
// Optional first-failure log enabled by defining OAI33_ARC_SEQUENCER_FAIL_LOG_EN.
module oai33_arc_sequencer
  import oai33_arc_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             zn,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  output logic             b1,
  output logic             b2,
  output logic             b3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt
`ifdef OAI33_ARC_SEQUENCER_FAIL_LOG_EN
  ,
  output logic [6:0]       fail_arc,
  output logic             fail_vld
`endif
);

  state_t           state, state_nxt;
  logic [2:0]       pin_q;
  logic [2:0]       cond_q;
  logic             phase_q;
  logic [3:0]       settle_q;
  logic [5:0]       drv_q;
  logic [CNT_W-1:0] err_q;
  logic             pass_q, busy_q, done_q;
  logic             exp_zn, mismatch, last_check, settle_done, launch, advance;

  oai33_golden_model u_golden (
    .a1(drv_q[5]),
    .a2(drv_q[4]),
    .a3(drv_q[3]),
    .b1(drv_q[2]),
    .b2(drv_q[1]),
    .b3(drv_q[0]),
    .zn(exp_zn)
  );

  assign mismatch    = (state == CHECK) && (zn != exp_zn);
  assign last_check  = (pin_q == 3'(PIN_B3)) && (cond_q == 3'(NUM_COND)) && phase_q;
  assign settle_done = (settle_q == 4'(SETTLE_CYCLES - 1));
  assign launch      = (state == IDLE) && (state_nxt == APPLY);
  assign advance     = (state == CHECK) && !abort;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = CHECK;
      CHECK:   state_nxt = last_check ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a START seen in the same IDLE cycle.
    if (abort) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q    <= '0;
      cond_q   <= '0;
      phase_q  <= 1'b0;
      settle_q <= '0;
      drv_q    <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_nxt == APPLY) || (state_nxt == SETTLE) || (state_nxt == CHECK);
      done_q <= (state_nxt == DONE);

      if (launch) begin
        pin_q   <= 3'(PIN_A1);
        cond_q  <= 3'd1;
        phase_q <= 1'b0;
        err_q   <= '0;
        pass_q  <= 1'b0;
      end

      if (state == APPLY)  settle_q <= '0;
      if (state == SETTLE) settle_q <= settle_q + 4'd1;

      if (state_nxt == IDLE || state_nxt == DONE) drv_q <= '0;
      else if (state == APPLY)                    drv_q <= arc_vector(pin_q, cond_q, phase_q);

      if (advance) begin
        if (mismatch && !(&err_q)) err_q <= err_q + 1'b1;
        phase_q <= ~phase_q;
        if (phase_q) begin
          if (cond_q == 3'(NUM_COND)) begin
            cond_q <= 3'd1;
            pin_q  <= pin_q + 3'd1;
          end else begin
            cond_q <= cond_q + 3'd1;
          end
        end
        if (last_check) pass_q <= (err_q == '0) && !mismatch;
      end

      if (abort && state != IDLE) pass_q <= 1'b0;
    end
  end

`ifdef OAI33_ARC_SEQUENCER_FAIL_LOG_EN
  logic [5:0] arc_idx;
  assign arc_idx = 6'(pin_q) * 6'd7 + 6'(cond_q) - 6'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_arc <= '0;
      fail_vld <= 1'b0;
    end else if (launch) begin
      fail_arc <= '0;
      fail_vld <= 1'b0;
    end else if (advance && mismatch && !fail_vld) begin
      fail_arc <= {arc_idx, phase_q};
      fail_vld <= 1'b1;
    end
  end
`endif

  assign {a1, a2, a3, b1, b2, b3} = drv_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_oai33_arc_sequencer.sv
// Directed, table-driven bench for oai33_arc_sequencer with a fault-injectable cell model.
module tb_oai33_arc_sequencer;

  localparam logic [1:0] F_GOOD = 2'd0;
  localparam logic [1:0] F_SA1  = 2'd1;
  localparam logic [1:0] F_SA0  = 2'd2;
  localparam logic [1:0] F_ARC6 = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       zn;
  logic       a1, a2, a3, b1, b2, b3;
  logic       busy, done, pass;
  logic [6:0] err_cnt;
  logic       good_zn;
  logic [1:0] fault = F_GOOD;
  logic [5:0] drvs;
`ifdef OAI33_ARC_SEQUENCER_FAIL_LOG_EN
  logic [6:0] fail_arc;
  logic       fail_vld;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  oai33_arc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .zn(zn),
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef OAI33_ARC_SEQUENCER_FAIL_LOG_EN
    , .fail_arc(fail_arc), .fail_vld(fail_vld)
`endif
  );

  oai33_golden_model u_cell (
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3), .zn(good_zn)
  );

  assign drvs = {a1, a2, a3, b1, b2, b3};

  always_comb begin
    zn = good_zn;
    case (fault)
      F_SA1:   zn = 1'b1;
      F_SA0:   zn = 1'b0;
      F_ARC6:  if (a1 && b1 && b2 && b3) zn = ~good_zn;
      default: zn = good_zn;
    endcase
  end

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Expected drive vector of check i, built straight from the enumeration order.
  function automatic logic [5:0] exp_drv(input int i);
    int arc, ph, pin, c;
    logic [2:0] grp_own, grp_side;
    arc = i / 2;
    ph  = i % 2;
    pin = arc / 7;
    c   = arc % 7 + 1;
    grp_side = 3'(c);
    grp_own  = (ph == 0) ? 3'(4 >> (pin % 3)) : 3'b000;
    return (pin < 3) ? {grp_own, grp_side} : {grp_side, grp_own};
  endfunction

  // Pulses START; returns the number of clocks from the START-sampling edge to DONE.
  task automatic run_to_done(input logic chk_drv, input int restart_k, output int k);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 1000) begin
      if (chk_drv && (k % 4 == 2))
        check($sformatf("drv%0d", k / 4), 32'(drvs), 32'(exp_drv(k / 4)));
      start = (k == restart_k);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done_latency", 32'(k), 32'd336);
  endtask

  typedef struct {
    string      name;
    logic [1:0] fault;
    logic       chk_drv;
    int         exp_err;
    logic       exp_pass;
    logic [6:0] exp_arc;
    logic       exp_vld;
  } sweep_t;

  sweep_t tbl[4];
  int     k;
  int     done_seen;

  initial begin
    tbl[0] = '{"sa1",  F_SA1,  1'b0, 42, 1'b0, 7'd0,  1'b1};
    tbl[1] = '{"sa0",  F_SA0,  1'b0, 42, 1'b0, 7'd1,  1'b1};
    tbl[2] = '{"arc6", F_ARC6, 1'b0, 1,  1'b0, 7'd12, 1'b1};
    tbl[3] = '{"good", F_GOOD, 1'b1, 0,  1'b1, 7'd0,  1'b0};

    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, pass, err_cnt, drvs}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {busy, done, pass, err_cnt, drvs}, '0);

    for (int i = 0; i < 4; i++) begin
      fault = tbl[i].fault;
      run_to_done(tbl[i].chk_drv, -1, k);
      check({tbl[i].name, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tbl[i].name, "_err"}, 32'(err_cnt), 32'(tbl[i].exp_err));
      check({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].exp_pass));
`ifdef OAI33_ARC_SEQUENCER_FAIL_LOG_EN
      check({tbl[i].name, "_fail_arc"}, 32'(fail_arc), 32'(tbl[i].exp_arc));
      check({tbl[i].name, "_fail_vld"}, 32'(fail_vld), 32'(tbl[i].exp_vld));
`endif
      @(negedge clk);
      check({tbl[i].name, "_post_done"}, {done, busy, drvs}, '0);
      check({tbl[i].name, "_pass_held"}, 32'(pass), 32'(tbl[i].exp_pass));
    end

    // Abort at clock 100 of a stuck-at-1 sweep: 25 checks done, 13 of them rises.
    fault = F_SA1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    check("busy_pre_abort", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_state", {busy, done, pass, drvs}, '0);
    check("abort_err_held", 32'(err_cnt), 32'd13);
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    // START and ABORT together in IDLE: stays idle, count untouched.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);
    check("start_abort_err", 32'(err_cnt), 32'd13);

    fault = F_GOOD;
    run_to_done(1'b0, -1, k);
    check("post_abort_pass", 32'(pass), 32'd1);
    check("post_abort_err", 32'(err_cnt), 32'd0);

    // Asynchronous reset at clock 50 of a stuck-at-1 sweep (12 checks done, 6 rises).
    fault = F_SA1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(negedge clk);
    check("err_pre_rst", 32'(err_cnt), 32'd6);
    #2 rst = 1'b1;
    #1 check("rst_async", {busy, done, pass, err_cnt, drvs}, '0);
    @(negedge clk) rst = 1'b0;

    // Clean sweep with a stray START while busy; DONE timing must not move.
    fault = F_GOOD;
    run_to_done(1'b0, 10, k);
    check("restart_pass", 32'(pass), 32'd1);
    check("restart_err", 32'(err_cnt), 32'd0);
    @(negedge clk);
    check("restart_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
